// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port registered-read RAM, with one response slot per port.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 always wins a tie.
//
// state         | meaning
// SLOT_EMPTY    | no read outstanding for this port
// SLOT_INFLIGHT | read issued last cycle, data comes straight from ram_rd_i
// SLOT_HELD     | requester stalled, data parked in the hold register
module ram_arbiter #(
  parameter  int XLen      = 32,
  parameter  int NPos      = 1024,
  localparam int NPosWidth = $clog2(NPos)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req0_valid_i,
  output logic                 req0_ready_o,
  input  logic                 req0_we_i,
  input  logic [NPosWidth-1:0] req0_addr_i,
  input  logic [XLen-1:0]      req0_wd_i,
  output logic                 rsp0_valid_o,
  input  logic                 rsp0_ready_i,
  output logic [XLen-1:0]      rsp0_rd_o,
  input  logic                 req1_valid_i,
  output logic                 req1_ready_o,
  input  logic                 req1_we_i,
  input  logic [NPosWidth-1:0] req1_addr_i,
  input  logic [XLen-1:0]      req1_wd_i,
  output logic                 rsp1_valid_o,
  input  logic                 rsp1_ready_i,
  output logic [XLen-1:0]      rsp1_rd_o,
  output logic [NPosWidth-1:0] ram_a_o,
  output logic [XLen-1:0]      ram_wd_o,
  output logic                 ram_we_o,
  input  logic [XLen-1:0]      ram_rd_i
);

  typedef enum logic [1:0] {
    SLOT_EMPTY    = 2'd0,
    SLOT_INFLIGHT = 2'd1,
    SLOT_HELD     = 2'd2
  } slot_e;

  slot_e                 slot_q [2];
  slot_e                 slot_d [2];
  logic [XLen-1:0]       hold_q [2];
  logic [1:0]            capture;
  logic [1:0]            valid;
  logic [1:0]            we;
  logic [1:0]            rsp_ready;
  logic [NPosWidth-1:0]  addr [2];
  logic [XLen-1:0]       wd [2];
  logic [XLen-1:0]       rsp_rd [2];
  logic [1:0]            rsp_valid;
  logic [1:0]            elig;
  logic [1:0]            grant;

  assign valid     = {req1_valid_i, req0_valid_i};
  assign we        = {req1_we_i, req0_we_i};
  assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};
  assign addr[0]   = req0_addr_i;
  assign addr[1]   = req1_addr_i;
  assign wd[0]     = req0_wd_i;
  assign wd[1]     = req1_wd_i;

  // A read may issue while the slot is still presenting, as long as that response drains now.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = valid[i] & (we[i] | (slot_q[i] == SLOT_EMPTY) | rsp_ready[i]);
    end
  end

`ifdef RAM_ARB_RR_EN
  logic last_q;  // port granted most recently

  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
    if (rst_i) begin
      grant = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (|grant) begin
      last_q <= grant[1];
    end
  end
`else
  always_comb begin
    grant    = '0;
    grant[0] = elig[0];
    grant[1] = elig[1] & ~elig[0];
    if (rst_i) begin
      grant = '0;
    end
  end
`endif

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  always_comb begin
    ram_a_o  = '0;
    ram_wd_o = '0;
    ram_we_o = 1'b0;
    if (grant[0]) begin
      ram_a_o  = addr[0];
      ram_wd_o = wd[0];
      ram_we_o = we[0];
    end else if (grant[1]) begin
      ram_a_o  = addr[1];
      ram_wd_o = wd[1];
      ram_we_o = we[1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= SLOT_EMPTY;
        hold_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= slot_d[i];
        if (capture[i]) begin
          hold_q[i] <= ram_rd_i;
        end
      end
    end
  end

  always_comb begin
    capture = '0;
    for (int i = 0; i < 2; i++) begin
      slot_d[i]    = slot_q[i];
      rsp_valid[i] = 1'b0;
      rsp_rd[i]    = '0;
      case (slot_q[i])
        SLOT_EMPTY: begin
          if (grant[i] && !we[i]) slot_d[i] = SLOT_INFLIGHT;
        end
        SLOT_INFLIGHT: begin
          rsp_valid[i] = 1'b1;
          rsp_rd[i]    = ram_rd_i;
          if (rsp_ready[i]) begin
            slot_d[i] = (grant[i] && !we[i]) ? SLOT_INFLIGHT : SLOT_EMPTY;
          end else begin
            capture[i] = 1'b1;
            slot_d[i]  = SLOT_HELD;
          end
        end
        SLOT_HELD: begin
          rsp_valid[i] = 1'b1;
          rsp_rd[i]    = hold_q[i];
          if (rsp_ready[i]) begin
            slot_d[i] = (grant[i] && !we[i]) ? SLOT_INFLIGHT : SLOT_EMPTY;
          end
        end
        default: slot_d[i] = SLOT_EMPTY;
      endcase
    end
  end

  assign rsp0_valid_o = rsp_valid[0];
  assign rsp1_valid_o = rsp_valid[1];
  assign rsp0_rd_o    = rsp_rd[0];
  assign rsp1_rd_o    = rsp_rd[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, reset-in-flight sequence, then random traffic
// against a queue-based reference model. Honours RAM_ARB_RR_EN like the design.
module tb_ram_arbiter;
  localparam int XLen = 32;
  localparam int NPos = 1024;
  localparam int AW   = 10;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic            req0_valid_i, req0_ready_o, req0_we_i;
  logic [AW-1:0]   req0_addr_i;
  logic [XLen-1:0] req0_wd_i;
  logic            rsp0_valid_o, rsp0_ready_i;
  logic [XLen-1:0] rsp0_rd_o;
  logic            req1_valid_i, req1_ready_o, req1_we_i;
  logic [AW-1:0]   req1_addr_i;
  logic [XLen-1:0] req1_wd_i;
  logic            rsp1_valid_o, rsp1_ready_i;
  logic [XLen-1:0] rsp1_rd_o;
  logic [AW-1:0]   ram_a_o;
  logic [XLen-1:0] ram_wd_o;
  logic            ram_we_o;
  logic [XLen-1:0] ram_rd_i;

  ram_arbiter #(.XLen(XLen), .NPos(NPos)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
    .req0_addr_i(req0_addr_i), .req0_wd_i(req0_wd_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i), .rsp0_rd_o(rsp0_rd_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
    .req1_addr_i(req1_addr_i), .req1_wd_i(req1_wd_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i), .rsp1_rd_o(rsp1_rd_o),
    .ram_a_o(ram_a_o), .ram_wd_o(ram_wd_o), .ram_we_o(ram_we_o), .ram_rd_i(ram_rd_i)
  );

  // Single-port RAM: registered read, read register frozen during a write.
  logic [XLen-1:0] mem [NPos];
  always @(posedge clk_i) begin
    if (ram_we_o) mem[ram_a_o] <= ram_wd_o;
    else          ram_rd_i     <= mem[ram_a_o];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic v0, we0, rr0, v1, we1, rr1;
    logic [AW-1:0]   a0, a1;
    logic [XLen-1:0] wd0, wd1;
    logic xr0, xr1, xv0, xv1;
    logic [XLen-1:0] xd0, xd1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
      input logic v0, input logic we0, input int a0, input logic [31:0] wd0, input logic rr0,
      input logic v1, input logic we1, input int a1, input logic [31:0] wd1, input logic rr1,
      input logic xr0, input logic xr1,
      input logic xv0, input logic [31:0] xd0, input logic xv1, input logic [31:0] xd1);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = AW'(a0); v.wd0 = wd0; v.rr0 = rr0;
    v.v1 = v1; v.we1 = we1; v.a1 = AW'(a1); v.wd1 = wd1; v.rr1 = rr1;
    v.xr0 = xr0; v.xr1 = xr1; v.xv0 = xv0; v.xd0 = xd0; v.xv1 = xv1; v.xd1 = xd1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req0_valid_i = v.v0; req0_we_i = v.we0; req0_addr_i = v.a0; req0_wd_i = v.wd0; rsp0_ready_i = v.rr0;
    req1_valid_i = v.v1; req1_we_i = v.we1; req1_addr_i = v.a1; req1_wd_i = v.wd1; rsp1_ready_i = v.rr1;
  endtask

  // Reference model state: per-port queue of expected read data, shadow memory, last grant.
  logic [XLen-1:0] ref_mem [16];
  logic [XLen-1:0] q0[$], q1[$];
  int last_g;
  logic            p_v[2], p_we[2], p_acc[2];
  logic [AW-1:0]   p_a[2];
  logic [XLen-1:0] p_wd[2];

  initial begin
    vec_t idle;
    for (int i = 0; i < NPos; i++) mem[i] = '0;
    mem[1] = 32'h0000_000A;
    mem[2] = 32'h0000_000B;
    mem[3] = 32'h0000_0033;
    mem[4] = 32'h0000_0044;
    mem[5] = 32'hDEAD_BEEF;

    // Reset with both requesters pushing: nothing may be granted or driven.
    idle = mk(0,0,0,0,1, 0,0,0,0,1, 0,0, 0,0, 0,0);
    drive(mk(1,1,7,32'hFFFF_FFFF,1, 1,0,6,0,1, 0,0, 0,0, 0,0));
    #12;
    chk("reset rdy0", req0_ready_o, 0);
    chk("reset rdy1", req1_ready_o, 0);
    chk("reset rv0", rsp0_valid_o, 0);
    chk("reset rv1", rsp1_valid_o, 0);
    chk("reset rd0", rsp0_rd_o, 0);
    chk("reset rd1", rsp1_rd_o, 0);
    chk("reset ram_we", ram_we_o, 0);
    chk("reset ram_a", ram_a_o, 0);
    chk("reset ram_wd", ram_wd_o, 0);
    drive(idle);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Single read, write-then-read.
    tbl.push_back(mk(1,0,5,0,1, 0,0,0,0,1, 1,0, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,1, 0,0, 1,32'hDEAD_BEEF, 0,0));
    tbl.push_back(mk(0,0,0,0,1, 1,1,9,32'h1234_5678,1, 0,1, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,1, 1,0,9,0,1, 0,1, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,1, 0,0, 0,0, 1,32'h1234_5678));
    // Tie: both read continuously.
`ifdef RAM_ARB_RR_EN
    tbl.push_back(mk(1,0,1,0,1, 1,0,2,0,1, 1,0, 0,0, 0,0));
    tbl.push_back(mk(1,0,1,0,1, 1,0,2,0,1, 0,1, 1,32'hA, 0,0));
    tbl.push_back(mk(1,0,1,0,1, 1,0,2,0,1, 1,0, 0,0, 1,32'hB));
    tbl.push_back(mk(1,0,1,0,1, 1,0,2,0,1, 0,1, 1,32'hA, 0,0));
    tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,1, 0,0, 0,0, 1,32'hB));
`else
    tbl.push_back(mk(1,0,1,0,1, 1,0,2,0,1, 1,0, 0,0, 0,0));
    tbl.push_back(mk(1,0,1,0,1, 1,0,2,0,1, 1,0, 1,32'hA, 0,0));
    tbl.push_back(mk(1,0,1,0,1, 1,0,2,0,1, 1,0, 1,32'hA, 0,0));
    tbl.push_back(mk(1,0,1,0,1, 1,0,2,0,1, 1,0, 1,32'hA, 0,0));
    tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,1, 0,0, 1,32'hA, 0,0));
`endif
    // Response stall on port 0 while port 1 proceeds, then drain-and-issue streaming.
    tbl.push_back(mk(1,0,3,0,0, 0,0,0,0,1, 1,0, 0,0, 0,0));
    tbl.push_back(mk(1,0,3,0,0, 1,0,4,0,1, 0,1, 1,32'h33, 0,0));
    tbl.push_back(mk(1,0,3,0,0, 0,0,0,0,1, 0,0, 1,32'h33, 1,32'h44));
    tbl.push_back(mk(1,0,3,0,0, 0,0,0,0,1, 0,0, 1,32'h33, 0,0));
    tbl.push_back(mk(1,0,3,0,1, 0,0,0,0,1, 1,0, 1,32'h33, 0,0));
    tbl.push_back(mk(1,0,5,0,1, 0,0,0,0,1, 1,0, 1,32'h33, 0,0));
    tbl.push_back(mk(1,0,1,0,1, 0,0,0,0,1, 1,0, 1,32'hDEAD_BEEF, 0,0));
    tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,1, 0,0, 1,32'hA, 0,0));
    tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,1, 0,0, 0,0, 0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clk_i);
      chk($sformatf("row%0d rdy0", i), req0_ready_o, tbl[i].xr0);
      chk($sformatf("row%0d rdy1", i), req1_ready_o, tbl[i].xr1);
      chk($sformatf("row%0d rv0", i), rsp0_valid_o, tbl[i].xv0);
      chk($sformatf("row%0d rv1", i), rsp1_valid_o, tbl[i].xv1);
      if (tbl[i].xv0) chk($sformatf("row%0d rd0", i), rsp0_rd_o, tbl[i].xd0);
      if (tbl[i].xv1) chk($sformatf("row%0d rd1", i), rsp1_rd_o, tbl[i].xd1);
      @(posedge clk_i); #1;
    end

    // Reset between read accept and response.
    drive(mk(1,0,2,0,0, 0,0,0,0,1, 0,0, 0,0, 0,0));
    @(posedge clk_i); #1;
    drive(idle);
    rsp0_ready_i = 1'b0;
    chk("midrst pre rv0", rsp0_valid_o, 1);
    rst_i = 1'b1;
    #1;
    chk("midrst rv0", rsp0_valid_o, 0);
    chk("midrst rd0", rsp0_rd_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    drive(mk(1,0,2,0,1, 0,0,0,0,1, 0,0, 0,0, 0,0));
    @(negedge clk_i);
    chk("midrst again rdy0", req0_ready_o, 1);
    @(posedge clk_i); #1;
    drive(idle);
    @(negedge clk_i);
    chk("midrst again rv0", rsp0_valid_o, 1);
    chk("midrst again rd0", rsp0_rd_o, 32'hB);
    @(posedge clk_i); #1;

    // Random traffic against the reference model.
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    last_g = 1;
    for (int a = 0; a < 16; a++) ref_mem[a] = mem[a];
    for (int i = 0; i < 2; i++) begin p_v[i] = 0; p_acc[i] = 1; p_we[i] = 0; p_a[i] = '0; p_wd[i] = '0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [1:0] elig, pend, rr;
      int g;
      logic [XLen-1:0] exp_rd [2];
      for (int i = 0; i < 2; i++) begin
        if (!p_v[i] || p_acc[i]) begin
          p_v[i]  = ($urandom_range(0, 3) != 0);
          p_we[i] = ($urandom_range(0, 2) == 0);
          p_a[i]  = AW'($urandom_range(0, 15));
          p_wd[i] = $urandom;
        end
        p_acc[i] = 0;
      end
      req0_valid_i = p_v[0]; req0_we_i = p_we[0]; req0_addr_i = p_a[0]; req0_wd_i = p_wd[0];
      req1_valid_i = p_v[1]; req1_we_i = p_we[1]; req1_addr_i = p_a[1]; req1_wd_i = p_wd[1];
      rsp0_ready_i = ($urandom_range(0, 3) != 0);
      rsp1_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk_i);
      rr = {rsp1_ready_i, rsp0_ready_i};
      pend = {q1.size() != 0, q0.size() != 0};
      exp_rd[0] = (q0.size() != 0) ? q0[0] : '0;
      exp_rd[1] = (q1.size() != 0) ? q1[0] : '0;
      for (int i = 0; i < 2; i++) elig[i] = p_v[i] & (p_we[i] | ~pend[i] | rr[i]);
      g = -1;
      if (elig == 2'b11) begin
`ifdef RAM_ARB_RR_EN
        g = (last_g == 1) ? 0 : 1;
`else
        g = 0;
`endif
      end else if (elig[0]) g = 0;
      else if (elig[1]) g = 1;
      chk("rand rdy0", req0_ready_o, g == 0);
      chk("rand rdy1", req1_ready_o, g == 1);
      chk("rand rv0", rsp0_valid_o, pend[0]);
      chk("rand rv1", rsp1_valid_o, pend[1]);
      if (pend[0]) chk("rand rd0", rsp0_rd_o, exp_rd[0]);
      if (pend[1]) chk("rand rd1", rsp1_rd_o, exp_rd[1]);
      chk("rand ram_we", ram_we_o, (g >= 0) ? p_we[g] : 1'b0);
      chk("rand ram_a", ram_a_o, (g >= 0) ? p_a[g] : '0);
      chk("rand ram_wd", ram_wd_o, (g >= 0) ? p_wd[g] : '0);
      if (pend[0] && rr[0]) void'(q0.pop_front());
      if (pend[1] && rr[1]) void'(q1.pop_front());
      if (g >= 0) begin
        if (p_we[g]) ref_mem[p_a[g][3:0]] = p_wd[g];
        else if (g == 0) q0.push_back(ref_mem[p_a[g][3:0]]);
        else q1.push_back(ref_mem[p_a[g][3:0]]);
        last_g = g;
        p_acc[g] = 1;
      end
      @(posedge clk_i); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
